// File: rtl/hwag_sync_ctrl.sv
// Tooth-wheel sync controller: times tooth periods, finds the missing-tooth gap, tracks tooth index.
// All outputs registered, one cycle after the edge pulse; no backpressure, every edge is processed.
module hwag_sync_ctrl #(
    parameter int WIDTH   = 24,
    parameter int TEETH   = 60,
    parameter int MISSING = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             ena_i,
    input  logic             edge_i,
    output logic             sync_o,
    output logic [7:0]       tooth_num_o,
    output logic             tooth_strobe_o,
    output logic             gap_strobe_o,
    output logic             sync_err_o,
    output logic             stall_o,
    output logic [WIDTH-1:0] period_o
);

    localparam logic [WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [WIDTH-1:0] CNT_PRESAT = CNT_MAX - WIDTH'(1);
    localparam logic [7:0]       LAST_TOOTH = 8'(TEETH - MISSING - 1);

    typedef enum logic [1:0] {IDLE, PRIME, SEARCH, SYNC} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] p0_q, p0_d, p1_q, p1_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [1:0]       vcnt_q, vcnt_d;
    logic [7:0]       tooth_q, tooth_d;
    logic             tstb_q, tstb_d, gstb_q, gstb_d, err_q, err_d, stall_q, stall_d;

    // Doubling in WIDTH+1 bits keeps the gap test free of wrap-around.
    logic [WIDTH:0] t_ext, p0_x2, p1_x2;
    logic           gap;

    assign t_ext = {1'b0, cnt_q};
    assign p0_x2 = {p0_q, 1'b0};
    assign p1_x2 = {p1_q, 1'b0};
    assign gap   = (t_ext > p0_x2) && (t_ext > p1_x2);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p0_d     = p0_q;
        p1_d     = p1_q;
        period_d = period_q;
        vcnt_d   = vcnt_q;
        tooth_d  = tooth_q;
        stall_d  = stall_q;
        tstb_d   = 1'b0;
        gstb_d   = 1'b0;
        err_d    = 1'b0;

        if (!ena_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            p0_d    = '0;
            p1_d    = '0;
            vcnt_d  = '0;
            tooth_d = '0;
            stall_d = 1'b0;
            err_d   = (state_q == SYNC);
        end else if (edge_i) begin
            cnt_d   = WIDTH'(1);
            stall_d = 1'b0;
            if (state_q != IDLE) begin
                p1_d = p0_q;
                p0_d = cnt_q;
            end
            case (state_q)
                IDLE: begin
                    state_d = PRIME;
                    vcnt_d  = '0;
                end
                PRIME: begin
                    // History is full once vcnt hits 2; the following edge enters SEARCH.
                    if (vcnt_q == 2'd2) state_d = SEARCH;
                    else                vcnt_d  = vcnt_q + 2'd1;
                end
                SEARCH: begin
                    if (gap) begin
                        state_d = SYNC;
                        tooth_d = '0;
                        gstb_d  = 1'b1;
                    end else begin
                        period_d = cnt_q;
                    end
                end
                SYNC: begin
                    if (!gap) period_d = cnt_q;
                    if (tooth_q == LAST_TOOTH) begin
                        if (gap) begin
                            tooth_d = '0;
                            tstb_d  = 1'b1;
                            gstb_d  = 1'b1;
                        end else begin
                            err_d   = 1'b1;
                            state_d = SEARCH;
                            tooth_d = '0;
                        end
                    end else if (!gap) begin
                        tooth_d = tooth_q + 8'd1;
                        tstb_d  = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = SEARCH;
                        tooth_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + WIDTH'(1);
            if (cnt_q == CNT_PRESAT) begin
                stall_d = 1'b1;
                state_d = IDLE;
                tooth_d = '0;
                err_d   = (state_q == SYNC);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            p0_q     <= '0;
            p1_q     <= '0;
            period_q <= '0;
            vcnt_q   <= '0;
            tooth_q  <= '0;
            tstb_q   <= 1'b0;
            gstb_q   <= 1'b0;
            err_q    <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p0_q     <= p0_d;
            p1_q     <= p1_d;
            period_q <= period_d;
            vcnt_q   <= vcnt_d;
            tooth_q  <= tooth_d;
            tstb_q   <= tstb_d;
            gstb_q   <= gstb_d;
            err_q    <= err_d;
            stall_q  <= stall_d;
        end
    end

    assign sync_o         = (state_q == SYNC);
    assign tooth_num_o    = tooth_q;
    assign tooth_strobe_o = tstb_q;
    assign gap_strobe_o   = gstb_q;
    assign sync_err_o     = err_q;
    assign stall_o        = stall_q;
    assign period_o       = period_q;

endmodule

// File: tb/tb_hwag_sync_ctrl.sv
// Directed wheel patterns on an 8-tooth / 2-missing wheel with a 6-bit timer; strobe events checked from a queue.
module tb_hwag_sync_ctrl;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena = 1'b1;
    logic         edge_p = 1'b0;
    logic         sync, tstb, gstb, serr, stall;
    logic [7:0]   tnum;
    logic [W-1:0] period;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic       ts;
        logic       gs;
        logic       se;
        logic       sy;
        logic [7:0] tn;
        logic [W-1:0] per;
    } exp_t;

    exp_t expq[$];

    hwag_sync_ctrl #(.WIDTH(W), .TEETH(8), .MISSING(2)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .ena_i(ena), .edge_i(edge_p),
        .sync_o(sync), .tooth_num_o(tnum), .tooth_strobe_o(tstb),
        .gap_strobe_o(gstb), .sync_err_o(serr), .stall_o(stall), .period_o(period)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Monitor: any strobe from the DUT must match the oldest queued expectation.
    always @(negedge clk) begin
        if (tstb || gstb || serr) begin
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe: got ts=%b gs=%b se=%b tn=%0d at %0t, expected none",
                         tstb, gstb, serr, tnum, $time);
            end else begin
                exp_t e;
                logic [17:0] a, x;
                e = expq.pop_front();
                a = {tstb, gstb, serr, sync, tnum, period};
                x = {e.ts, e.gs, e.se, e.sy, e.tn, e.per};
                if (a !== x) begin
                    bad++;
                    $display("FAIL strobe_event: got ts/gs/se/sy=%b%b%b%b tn=%0d per=%0d, expected %b%b%b%b tn=%0d per=%0d at %0t",
                             tstb, gstb, serr, sync, tnum, period,
                             e.ts, e.gs, e.se, e.sy, e.tn, e.per, $time);
                end
            end
        end
    end

    // Edge pulse n cycles after the previous one; optionally queue the expected strobe result.
    task automatic pulse(input int n, input bit use_exp, input exp_t e);
        repeat (n - 1) @(posedge clk);
        #1 edge_p = 1'b1;
        if (use_exp) expq.push_back(e);
        @(posedge clk);
        #1 edge_p = 1'b0;
    endtask

    task automatic pn(input int n);
        exp_t e;
        e = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, '0};
        pulse(n, 1'b0, e);
    endtask

    task automatic pe(input int n, input bit ts, input bit gs, input bit se,
                      input bit sy, input int tn, input int per);
        exp_t e;
        e = '{ts, gs, se, sy, 8'(tn), W'(per)};
        pulse(n, 1'b1, e);
    endtask

    initial begin
        exp_t e;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sync", sync, 0);
        chk("rst_tooth_num", tnum, 0);
        chk("rst_tooth_strobe", tstb, 0);
        chk("rst_gap_strobe", gstb, 0);
        chk("rst_sync_err", serr, 0);
        chk("rst_stall", stall, 0);
        chk("rst_period", period, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Start mid-revolution: discarded first edge, history fill, then the gap.
        pn(3);
        for (int i = 0; i < 4; i++) pn(10);
        pe(30, 0, 1, 0, 1, 0, 10);
        chk("sync_after_first_gap", sync, 1);
        for (int r = 0; r < 3; r++) begin
            for (int t = 1; t <= 5; t++) pe(10, 1, 0, 0, 1, t, 10);
            pe(30, 1, 1, 0, 1, 0, 10);
        end

        // Extra edge inside the gap: two 15-cycle periods.
        for (int t = 1; t <= 5; t++) pe(10, 1, 0, 0, 1, t, 10);
        pe(15, 0, 0, 1, 0, 0, 15);
        chk("sync_after_split_gap", sync, 0);
        pn(15);
        chk("period_in_search", period, 15);
        for (int t = 1; t <= 5; t++) pn(10);
        pe(30, 0, 1, 0, 1, 0, 10);

        // Expected gap missing.
        for (int t = 1; t <= 5; t++) pe(10, 1, 0, 0, 1, t, 10);
        pe(10, 0, 0, 1, 0, 0, 10);
        chk("sync_after_missing_gap", sync, 0);
        for (int t = 1; t <= 5; t++) pn(10);
        pe(30, 0, 1, 0, 1, 0, 10);

        // Acceleration 10 -> 8 -> 6 with gap at 3x the last tooth.
        pe(10, 1, 0, 0, 1, 1, 10);
        pe(8,  1, 0, 0, 1, 2, 8);
        pe(6,  1, 0, 0, 1, 3, 6);
        pe(6,  1, 0, 0, 1, 4, 6);
        pe(6,  1, 0, 0, 1, 5, 6);
        pe(18, 1, 1, 0, 1, 0, 6);
        for (int t = 1; t <= 5; t++) pe(6, 1, 0, 0, 1, t, 6);
        pe(18, 1, 1, 0, 1, 0, 6);
        chk("period_after_accel", period, 6);

        // Sensor stall: timer saturates at 63 cycles after the last edge.
        e = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0, W'(6)};
        expq.push_back(e);
        repeat (55) @(posedge clk);
        #1 chk("stall_not_early", stall, 0);
        repeat (15) @(posedge clk);
        #1;
        chk("stall_set", stall, 1);
        chk("sync_on_stall", sync, 0);
        pn(1);
        chk("stall_cleared_by_edge", stall, 0);
        for (int i = 0; i < 4; i++) pn(10);
        pe(30, 0, 1, 0, 1, 0, 10);

        // Enable dropped mid-SYNC.
        pe(10, 1, 0, 0, 1, 1, 10);
        pe(10, 1, 0, 0, 1, 2, 10);
        repeat (3) @(posedge clk);
        #1 ena = 1'b0;
        e = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0, W'(10)};
        expq.push_back(e);
        @(posedge clk);
        #1 chk("sync_after_ena_drop", sync, 0);
        repeat (4) @(posedge clk);
        #1 ena = 1'b1;
        pn(5);
        for (int i = 0; i < 4; i++) pn(10);
        pe(30, 0, 1, 0, 1, 0, 10);

        // Reset mid-revolution drops sync asynchronously without an error pulse.
        pe(10, 1, 0, 0, 1, 1, 10);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_sync", sync, 0);
        chk("async_rst_tooth_num", tnum, 0);
        chk("async_rst_period", period, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 chk("queue_drained", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
